rpn_evaluator: RTL and testbench

//  Consumer end of the infix->RPN path: pops postfix tokens from the ShuntingYard output queue,

---
 rtl/rpn_evaluator_if.sv | 22 ++
 rtl/rpn_evaluator.sv | 230 +++++++++++++++++++++++
 tb/tb_rpn_evaluator.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/rpn_evaluator_if.sv
// rpn_evaluator_if: token-queue handshake and result bundle for rpn_evaluator.
// master = token source / result consumer side, slave = evaluator side.
interface rpn_evaluator_if;
    logic        in_valid;
    logic [31:0] token;
    logic        rd_en;
    logic        in_ready;
    logic [31:0] result;
    logic        result_valid;
    logic        busy;
    logic [1:0]  error;

    modport master (
        output in_valid, token,
        input  rd_en, in_ready, result, result_valid, busy, error
    );

    modport slave (
        input  in_valid, token,
        output rd_en, in_ready, result, result_valid, busy, error
    );
endinterface

// File: rtl/rpn_evaluator.sv
// rpn_evaluator: pops postfix tokens from the parser queue, evaluates them on an
// operand stack and posts the 32-bit result on each '=' token.
// Optional feature macro: RPN_EVAL_DIV_EN enables the signed divider (DIV/DIVFIX);
// without it a '/' token is reported as error 3 (unsupported).
module rpn_evaluator #(
    parameter int DEPTH = 16,
    parameter int PTR_W = 5
) (
    input logic            clk,
    input logic            rst_n,
    rpn_evaluator_if.slave bus
);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [31:0] TOK_ADD = 32'h8000_000A;
    localparam logic [31:0] TOK_SUB = 32'h8000_000B;
    localparam logic [31:0] TOK_MUL = 32'h8000_000C;
    localparam logic [31:0] TOK_DIV = 32'h8000_000D;
    localparam logic [31:0] TOK_EQ  = 32'h8000_000E;
    localparam logic [31:0] TOK_CLR = 32'h8000_000F;

    localparam logic [PTR_W-1:0] SP_FULL = PTR_W'(DEPTH);
    localparam logic [PTR_W-1:0] SP_ONE  = PTR_W'(1);
    localparam logic [PTR_W-1:0] SP_TWO  = PTR_W'(2);

    typedef enum logic [2:0] {IDLE, PUSH, EXEC, DIV, DIVFIX, EMIT, ERROR} state_t;

    state_t           state, state_next;
    logic [31:0]      stack [DEPTH];
    logic [PTR_W-1:0] sp;
    logic [31:0]      tok_q;
    logic [31:0]      result_q;
    logic             result_valid_q;
    logic [1:0]       error_q;
    logic             in_ready;
    logic             busy;
    logic             accept;
    logic             full;
    logic             have_two;
    logic [IDX_W-1:0] idx_a, idx_b;
    logic [31:0]      a_val, b_val, alu_out;

    assign accept   = bus.in_valid & in_ready;
    assign full     = (sp == SP_FULL);
    assign have_two = (sp >= SP_TWO);
    assign idx_a    = sp[IDX_W-1:0] - IDX_W'(2);
    assign idx_b    = sp[IDX_W-1:0] - IDX_W'(1);
    assign a_val    = stack[idx_a];
    assign b_val    = stack[idx_b];

    assign bus.rd_en        = accept;
    assign bus.in_ready     = in_ready;
    assign bus.busy         = busy;
    assign bus.result       = result_q;
    assign bus.result_valid = result_valid_q;
    assign bus.error        = error_q;

    // Single-cycle arithmetic for + - * (wraps mod 2^32)
    always_comb begin
        alu_out = a_val + b_val;
        case (tok_q)
            TOK_SUB: alu_out = a_val - b_val;
            TOK_MUL: alu_out = a_val * b_val;
            default: alu_out = a_val + b_val;
        endcase
    end

`ifdef RPN_EVAL_DIV_EN
    logic [31:0] div_rem, div_quo, div_dvs;
    logic [5:0]  div_cnt;
    logic        div_neg;
    logic [32:0] div_shift, div_diff;
    logic [31:0] a_abs, b_abs, div_q_signed;

    assign div_shift    = {div_rem, div_quo[31]};
    assign div_diff     = div_shift - {1'b0, div_dvs};
    assign a_abs        = a_val[31] ? (32'd0 - a_val) : a_val;
    assign b_abs        = b_val[31] ? (32'd0 - b_val) : b_val;
    assign div_q_signed = div_neg ? (32'd0 - div_quo) : div_quo;
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Next-state decode, handshake and busy flag
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        busy       = 1'b1;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (bus.in_valid) begin
                    case (bus.token)
                        TOK_ADD, TOK_SUB, TOK_MUL: state_next = EXEC;
`ifdef RPN_EVAL_DIV_EN
                        TOK_DIV: state_next = DIV;
`else
                        TOK_DIV: state_next = ERROR;
`endif
                        TOK_EQ:  state_next = EMIT;
                        TOK_CLR: state_next = IDLE;
                        default: state_next = PUSH;
                    endcase
                end
            end
            PUSH: state_next = full ? ERROR : IDLE;
            EXEC: state_next = have_two ? IDLE : ERROR;
`ifdef RPN_EVAL_DIV_EN
            DIV: begin
                if (div_cnt == '0) begin
                    if (!have_two || (b_val == '0)) state_next = ERROR;
                end else if (div_cnt == 6'd32) begin
                    state_next = DIVFIX;
                end
            end
            DIVFIX: state_next = IDLE;
`endif
            EMIT: state_next = (sp == SP_ONE) ? IDLE : ERROR;
            ERROR: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (bus.in_valid && (bus.token == TOK_CLR)) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Stack pointer, result, error and divider control registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sp             <= '0;
            tok_q          <= '0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
            error_q        <= '0;
`ifdef RPN_EVAL_DIV_EN
            div_rem        <= '0;
            div_quo        <= '0;
            div_dvs        <= '0;
            div_cnt        <= '0;
            div_neg        <= 1'b0;
`endif
        end else begin
            result_valid_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        tok_q <= bus.token;
                        // result is registered on acceptance so the new value and
                        // its valid pulse are both visible during the EMIT cycle
                        if ((bus.token == TOK_EQ) && (sp == SP_ONE)) begin
                            result_q       <= stack[0];
                            result_valid_q <= 1'b1;
                        end
                        if (bus.token == TOK_CLR) begin
                            sp      <= '0;
                            error_q <= '0;
                        end
                        if (bus.token == TOK_DIV) begin
`ifdef RPN_EVAL_DIV_EN
                            div_cnt <= '0;
`else
                            error_q <= 2'd3;
`endif
                        end
                    end
                end
                PUSH: begin
                    if (full) error_q <= 2'd2;
                    else      sp      <= sp + SP_ONE;
                end
                EXEC: begin
                    if (!have_two) error_q <= 2'd1;
                    else           sp      <= sp - SP_ONE;
                end
`ifdef RPN_EVAL_DIV_EN
                DIV: begin
                    if (div_cnt == '0) begin
                        if (!have_two) begin
                            error_q <= 2'd1;
                        end else if (b_val == '0) begin
                            error_q <= 2'd3;
                        end else begin
                            div_rem <= '0;
                            div_quo <= a_abs;
                            div_dvs <= b_abs;
                            div_neg <= a_val[31] ^ b_val[31];
                            div_cnt <= 6'd1;
                        end
                    end else begin
                        // one restoring step per cycle, quotient bits shift into div_quo
                        div_rem <= div_diff[32] ? div_shift[31:0] : div_diff[31:0];
                        div_quo <= {div_quo[30:0], ~div_diff[32]};
                        div_cnt <= div_cnt + 6'd1;
                    end
                end
                DIVFIX: sp <= sp - SP_ONE;
`endif
                EMIT: begin
                    if (sp == SP_ONE) sp      <= '0;
                    else              error_q <= 2'd1;
                end
                ERROR: begin
                    if (accept && (bus.token == TOK_CLR)) begin
                        sp      <= '0;
                        error_q <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Operand stack storage (no reset; sp defines which entries are live)
    always_ff @(posedge clk) begin
        if ((state == PUSH) && !full)
            stack[sp[IDX_W-1:0]] <= tok_q;
        else if ((state == EXEC) && have_two)
            stack[idx_a] <= alu_out;
`ifdef RPN_EVAL_DIV_EN
        else if (state == DIVFIX)
            stack[idx_a] <= div_q_signed;
`endif
    end
endmodule

// File: tb/tb_rpn_evaluator.sv
// tb_rpn_evaluator: directed vector table plus hand sequences for latency,
// error handling, stack limits and asynchronous reset of rpn_evaluator.
module tb_rpn_evaluator;
    localparam logic [31:0] ADD = 32'h8000_000A;
    localparam logic [31:0] SUB = 32'h8000_000B;
    localparam logic [31:0] MUL = 32'h8000_000C;
    localparam logic [31:0] DIV = 32'h8000_000D;
    localparam logic [31:0] EQ  = 32'h8000_000E;
    localparam logic [31:0] CLR = 32'h8000_000F;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    rpn_evaluator_if bus();

    rpn_evaluator #(.DEPTH(16), .PTR_W(5)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    typedef struct {
        int          first;
        int          count;
        logic [31:0] exp_result;
        logic [1:0]  exp_error;
        int          exp_pulses;
    } vec_t;

    vec_t        vecs[$];
    logic [31:0] pool[$];
    int          cur_first = 0;

    int n_checks = 0;
    int n_errors = 0;
    int pulses   = 0;
    int rd_bad   = 0;

    always @(negedge clk) begin
        if (bus.result_valid) pulses++;
        if (bus.rd_en && !bus.in_valid) rd_bad++;
        if (bus.rd_en !== (bus.in_valid & bus.in_ready)) rd_bad++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got running want finished");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
        end
    endtask

    task automatic tk(input logic [31:0] v);
        pool.push_back(v);
    endtask

    task automatic vec_end(input logic [31:0] r, input logic [1:0] e, input int p);
        vec_t v;
        v.first      = cur_first;
        v.count      = pool.size() - cur_first;
        v.exp_result = r;
        v.exp_error  = e;
        v.exp_pulses = p;
        vecs.push_back(v);
        cur_first = pool.size();
    endtask

    task automatic send(input logic [31:0] t);
        int n = 0;
        @(negedge clk);
        while (!bus.in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!bus.in_ready) begin
            n_checks++;
            n_errors++;
            $display("FAIL send timeout: in_ready got 0 want 1 (token 0x%08h)", t);
        end
        bus.in_valid = 1'b1;
        bus.token    = t;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.token    = $urandom();
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        @(negedge clk);
        while (bus.busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (bus.busy) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s idle timeout: busy got 1 want 0", name);
        end
    endtask

    initial begin
        int p0;
        int n;

        // vector table: tokens, expected result, error, result_valid pulses
        tk(3); tk(4); tk(ADD); tk(2); tk(MUL); tk(EQ);        vec_end(32'd14, 2'd0, 1);
        tk(EQ);                                               vec_end(32'd14, 2'd1, 0);
        tk(10); tk(3); tk(SUB); tk(EQ);                       vec_end(32'd7, 2'd0, 1);
        tk(3); tk(10); tk(SUB); tk(EQ);                       vec_end(32'hFFFF_FFF9, 2'd0, 1);
        tk(32'hFFFF_FFFC); tk(5); tk(MUL); tk(EQ);            vec_end(32'hFFFF_FFEC, 2'd0, 1);
        tk(32'h7FFF_FFFF); tk(1); tk(ADD); tk(EQ);            vec_end(32'h8000_0000, 2'd0, 1);
        tk(32'h0001_0001); tk(32'h0001_0001); tk(MUL); tk(EQ); vec_end(32'h0002_0001, 2'd0, 1);
        tk(5); tk(ADD);                                       vec_end(32'h0002_0001, 2'd1, 0);
        tk(1); tk(2); tk(EQ);                                 vec_end(32'h0002_0001, 2'd1, 0);
        tk(5); tk(0); tk(DIV);                                vec_end(32'h0002_0001, 2'd3, 0);
        tk(42); tk(EQ);                                       vec_end(32'h0000_002A, 2'd0, 1);
        tk(32'h8000_0009); tk(0); tk(ADD); tk(EQ);            vec_end(32'h8000_0009, 2'd0, 1);
`ifdef RPN_EVAL_DIV_EN
        tk(7); tk(32'hFFFF_FFFE); tk(DIV); tk(EQ);            vec_end(32'hFFFF_FFFD, 2'd0, 1);
        tk(32'hFFFF_FFF9); tk(2); tk(DIV); tk(EQ);            vec_end(32'hFFFF_FFFD, 2'd0, 1);
        tk(32'h8000_0000); tk(32'hFFFF_FFFF); tk(DIV); tk(EQ); vec_end(32'h8000_0000, 2'd0, 1);
        tk(100); tk(7); tk(DIV); tk(EQ);                      vec_end(32'd14, 2'd0, 1);
        tk(10); tk(3); tk(DIV); tk(2); tk(MUL); tk(EQ);       vec_end(32'd6, 2'd0, 1);
`else
        tk(6); tk(3); tk(DIV);                                vec_end(32'h8000_0009, 2'd3, 0);
`endif

        // reset state
        bus.in_valid = 1'b0;
        bus.token    = '0;
        repeat (3) @(negedge clk);
        check("reset result", bus.result, 32'd0);
        check("reset result_valid", 32'(bus.result_valid), 32'd0);
        check("reset error", 32'(bus.error), 32'd0);
        check("reset busy", 32'(bus.busy), 32'd0);
        check("reset in_ready", 32'(bus.in_ready), 32'd1);
        check("reset rd_en", 32'(bus.rd_en), 32'd0);
        rst_n = 1'b1;

        // push and '=' latency
        send(32'd6);
        check("push T+1 in_ready", 32'(bus.in_ready), 32'd0);
        check("push T+1 busy", 32'(bus.busy), 32'd1);
        @(negedge clk);
        check("push T+1 negedge in_ready", 32'(bus.in_ready), 32'd0);
        @(negedge clk);
        check("push T+2 in_ready", 32'(bus.in_ready), 32'd1);
        send(EQ);
        check("emit T+1 result_valid", 32'(bus.result_valid), 32'd1);
        check("emit T+1 result", bus.result, 32'd6);
        @(negedge clk);
        @(negedge clk);
        check("emit T+2 result_valid", 32'(bus.result_valid), 32'd0);

        // table-driven vectors
        for (int i = 0; i < vecs.size(); i++) begin
            send(CLR);
            p0 = pulses;
            for (int k = 0; k < vecs[i].count; k++) send(pool[vecs[i].first + k]);
            wait_idle($sformatf("vec%0d", i));
            @(negedge clk);
            check($sformatf("vec%0d result", i), bus.result, vecs[i].exp_result);
            check($sformatf("vec%0d error", i), 32'(bus.error), 32'(vecs[i].exp_error));
            check($sformatf("vec%0d pulses", i), 32'(pulses - p0), 32'(vecs[i].exp_pulses));
        end

        // ERROR state discards tokens until clear
        send(CLR);
        send(5); send(0); send(DIV);
        wait_idle("div0");
        check("div0 error", 32'(bus.error), 32'd3);
        check("div0 in_ready", 32'(bus.in_ready), 32'd1);
        send(1); send(ADD);
        wait_idle("discard");
        check("discard error", 32'(bus.error), 32'd3);
        check("discard busy", 32'(bus.busy), 32'd0);
        send(CLR);
        wait_idle("clear");
        check("clear error", 32'(bus.error), 32'd0);
        check("clear busy", 32'(bus.busy), 32'd0);
        send(9); send(EQ);
        wait_idle("after clear");
        @(negedge clk);
        check("after clear result", bus.result, 32'd9);

        // stack depth limits
        send(CLR);
        for (int k = 1; k <= 16; k++) send(32'(k));
        wait_idle("full16");
        check("16 pushes error", 32'(bus.error), 32'd0);
        send(32'd17);
        wait_idle("push17");
        check("17th push error", 32'(bus.error), 32'd2);
        send(CLR);
        wait_idle("clear2");
        check("clear after overflow error", 32'(bus.error), 32'd0);
        for (int k = 1; k <= 16; k++) send(32'(k));
        for (int k = 0; k < 15; k++) send(ADD);
        send(EQ);
        wait_idle("sum16");
        @(negedge clk);
        check("sum 1..16 result", bus.result, 32'd136);
        check("sum 1..16 error", 32'(bus.error), 32'd0);

`ifdef RPN_EVAL_DIV_EN
        // divide latency: in_ready low 34 cycles after '/'
        send(CLR);
        send(7); send(32'hFFFF_FFFE); send(DIV);
        n = 0;
        @(negedge clk);
        while (!bus.in_ready && n < 100) begin
            n++;
            @(negedge clk);
        end
        check("div in_ready low cycles", 32'(n), 32'd34);
        send(EQ);
        wait_idle("div eq");
        @(negedge clk);
        check("div 7/-2 result", bus.result, 32'hFFFF_FFFD);
`endif

        // asynchronous reset while busy
        send(CLR);
`ifdef RPN_EVAL_DIV_EN
        send(7); send(32'hFFFF_FFFE); send(DIV);
        repeat (10) @(negedge clk);
`else
        send(9);
`endif
        check("pre-reset busy", 32'(bus.busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("async reset result", bus.result, 32'd0);
        check("async reset result_valid", 32'(bus.result_valid), 32'd0);
        check("async reset error", 32'(bus.error), 32'd0);
        check("async reset busy", 32'(bus.busy), 32'd0);
        check("async reset in_ready", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        send(2); send(3); send(SUB); send(EQ);
        wait_idle("post reset");
        @(negedge clk);
        check("post reset 2-3 result", bus.result, 32'hFFFF_FFFF);
        check("post reset error", 32'(bus.error), 32'd0);

        check("rd_en handshake rule violations", 32'(rd_bad), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
